// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: multi-channel servo PWM generator that drives pumps.
// A single shared frame counter times the pulses for every channel.
// Each position select is synchronised and debounced. The pulse width
// approaches its target by at most STEP per frame, and each pump runs
// while its select is low.
// Optional feature: define RAIN_LOCK_EN to add a debounced rain input.
// While that input reads 1, it forces every pump off.
module servo_pwm_bank #(
  parameter int NCH     = 3,
  parameter int CW      = 20,
  parameter int PERIOD  = 1_000_000,
  parameter int POS_A   = 30_000,
  parameter int POS_B   = 85_000,
  parameter int STEP    = 2_500,
  parameter int DEB_CYC = 500_000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] sel,
`ifdef RAIN_LOCK_EN
  input  logic           rain,
`endif
  output logic [NCH-1:0] servo,
  output logic [NCH-1:0] pump,
  output logic           frame_st,
  output logic           busy
);

  // The rain input, when present, shares the select conditioning path as its top bit
`ifdef RAIN_LOCK_EN
  localparam int NIN = NCH + 1;
`else
  localparam int NIN = NCH;
`endif

  // The stability counter counts 0..DEB_CYC-1, so at least one bit is needed
  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] POS_A_W  = CW'(POS_A);
  localparam logic [CW-1:0] POS_B_W  = CW'(POS_B);
  localparam logic [CW:0]   STEP_W   = (CW + 1)'(STEP);

  // Stop elaboration on parameter sets the counter and slew logic cannot honour
  if ((POS_A >= PERIOD) || (POS_B >= PERIOD) || (STEP == 0) ||
      ((2 ** CW) <= PERIOD) || (NCH < 1) || (NCH > 8) || (DEB_CYC < 1)) begin : g_param_check
    $error("servo_pwm_bank: illegal parameter combination");
  end

  // ---------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------
  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync1;
  logic [NIN-1:0] sync2;
  logic [NIN-1:0] deb;
  logic [DW-1:0]  deb_cnt [NIN];
  logic [NCH-1:0] deb_sel;
  logic           deb_rain;

`ifdef RAIN_LOCK_EN
  assign raw      = {rain, sel};
  assign deb_rain = deb[NCH];
`else
  assign raw      = sel;
  assign deb_rain = 1'b0;
`endif
  assign deb_sel = deb[NCH-1:0];

  // Two-flop synchroniser for every asynchronous input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // The debounced value follows the synchronised value after DEB_CYC cycles of disagreement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < NIN; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // Frame timing
  // ---------------------------------------------------------------
  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CNT_LAST);

  // Shared frame counter that runs 0..PERIOD-1 and then wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // frame_st has the same one-cycle lag as the servo pins, so it marks their first frame cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_st <= 1'b0;
    end else begin
      frame_st <= (cnt == '0);
    end
  end

  // ---------------------------------------------------------------
  // Targets and slew limiting
  // ---------------------------------------------------------------
  logic [CW-1:0]  pw      [NCH];
  logic [CW-1:0]  tgt     [NCH];
  logic [CW-1:0]  pw_next [NCH];
  logic [CW:0]    pw_ext  [NCH];
  logic [CW:0]    tgt_ext [NCH];
  logic [CW:0]    up_ext  [NCH];
  logic [CW:0]    dn_ext  [NCH];
  logic [CW:0]    lim_ext [NCH];
  logic [NCH-1:0] off_tgt;

  // Select the target for each channel and flag any channel that has not reached it
  always_comb begin
    off_tgt = '0;
    for (int i = 0; i < NCH; i++) begin
      tgt[i]     = deb_sel[i] ? POS_A_W : POS_B_W;
      off_tgt[i] = (pw[i] != tgt[i]);
    end
  end

  // Compute one slew step in CW+1 bits so that neither direction can wrap or overshoot
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pw_ext[i]  = {1'b0, pw[i]};
      tgt_ext[i] = {1'b0, tgt[i]};
      up_ext[i]  = pw_ext[i] + STEP_W;
      dn_ext[i]  = pw_ext[i] - STEP_W;
      lim_ext[i] = tgt_ext[i] + STEP_W;
      pw_next[i] = pw[i];
      if (pw_ext[i] < tgt_ext[i]) begin
        if (up_ext[i] < tgt_ext[i]) begin
          pw_next[i] = up_ext[i][CW-1:0];
        end else begin
          pw_next[i] = tgt[i];
        end
      end else if (pw_ext[i] > tgt_ext[i]) begin
        if (pw_ext[i] > lim_ext[i]) begin
          pw_next[i] = dn_ext[i][CW-1:0];
        end else begin
          pw_next[i] = tgt[i];
        end
      end
    end
  end

  // Pulse widths change only on the wrap cycle, so a frame's pulse is never cut short or stretched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        pw[i] <= POS_B_W;
      end
    end else if (wrap) begin
      for (int i = 0; i < NCH; i++) begin
        pw[i] <= pw_next[i];
      end
    end
  end

  // ---------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------

  // The PWM pin is high for the first pw[i] counts of every frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      servo <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        servo[i] <= (cnt < pw[i]);
      end
    end
  end

  // busy reports whether any channel is still ramping toward its target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
    end else begin
      busy <= |off_tgt;
    end
  end

  // A pump runs while its select is low, and debounced rain blocks all pumps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pump <= '0;
    end else begin
      pump <= ~deb_sel & ~{NCH{deb_rain}};
    end
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// tb_servo_pwm_bank: frame-level checks of servo_pwm_bank at small sim parameters.
// Pulse widths are counted over whole frames and compared with a slew model.
// The model works only in frame-level terms: target, step size and clamp.
module tb_servo_pwm_bank;

  localparam int NCH     = 3;
  localparam int CW      = 10;
  localparam int PERIOD  = 1000;
  localparam int POS_A   = 300;
  localparam int POS_B   = 850;
  localparam int STEP    = 100;
  localparam int DEB_CYC = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] sel = '0;
`ifdef RAIN_LOCK_EN
  logic           rain = 1'b0;
`endif
  logic [NCH-1:0] servo;
  logic [NCH-1:0] pump;
  logic           frame_st;
  logic           busy;

  int test_count = 0;
  int fail_count = 0;
  int frame_no   = 0;

  int             pw_m [NCH];
  logic [NCH-1:0] sel_m;

  servo_pwm_bank #(
    .NCH(NCH), .CW(CW), .PERIOD(PERIOD), .POS_A(POS_A), .POS_B(POS_B),
    .STEP(STEP), .DEB_CYC(DEB_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sel(sel),
`ifdef RAIN_LOCK_EN
    .rain(rain),
`endif
    .servo(servo),
    .pump(pump),
    .frame_st(frame_st),
    .busy(busy)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  function automatic int target_of(input logic b);
    return b ? POS_A : POS_B;
  endfunction

  // One frame's movement: advance at most STEP toward the target and never pass it
  function automatic int slew_toward(input int pw, input int tgt);
    if (tgt > pw) return (tgt - pw > STEP) ? pw + STEP : tgt;
    if (pw > tgt) return (pw - tgt > STEP) ? pw - STEP : tgt;
    return pw;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Run one full frame. At cnt==change_pos, sel changes to new_sel.
  // A 3-cycle glitch may also be applied to channel glitch_ch.
  // At the end of the frame, the measured output is compared with the model.
  task automatic apply_stimulus(input logic [NCH-1:0] new_sel, input int change_pos,
                                input int glitch_ch, input int glitch_pos);
    int             hi [NCH];
    int             fst_first;
    int             fst_other;
    logic [NCH-1:0] exp_pump;
    logic           exp_busy;
    fst_first = 0;
    fst_other = 0;
    for (int i = 0; i < NCH; i++) hi[i] = 0;
    for (int k = 1; k <= PERIOD; k++) begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) if (servo[i] === 1'b1) hi[i]++;
      if (frame_st === 1'b1) begin
        if (k == 1) fst_first++;
        else        fst_other++;
      end
      if (k == 1) begin
        exp_pump = ~sel_m;
        check_output($sformatf("pump_frame_start_f%0d", frame_no), pump, exp_pump);
      end
      if (glitch_ch >= 0 && (k == glitch_pos || k == glitch_pos + 3))
        sel[glitch_ch] = ~sel[glitch_ch];
      if (k == change_pos) sel = new_sel;
    end
    sel_m = new_sel;
    for (int i = 0; i < NCH; i++)
      check_output($sformatf("width_ch%0d_f%0d", i, frame_no), hi[i], pw_m[i]);
    check_output($sformatf("frame_st_first_f%0d", frame_no), fst_first, 1);
    check_output($sformatf("frame_st_extra_f%0d", frame_no), fst_other, 0);
    exp_busy = 1'b0;
    for (int i = 0; i < NCH; i++) if (pw_m[i] != target_of(sel_m[i])) exp_busy = 1'b1;
    check_output($sformatf("busy_f%0d", frame_no), busy, exp_busy);
    exp_pump = ~sel_m;
    check_output($sformatf("pump_f%0d", frame_no), pump, exp_pump);
    for (int i = 0; i < NCH; i++) pw_m[i] = slew_toward(pw_m[i], target_of(sel_m[i]));
    frame_no++;
  endtask

  initial begin
    logic [NCH-1:0] rnd_sel;
    logic [NCH-1:0] exp_vec;
    int             g;
    sel_m = '0;
    for (int i = 0; i < NCH; i++) pw_m[i] = POS_B;

    // Reset held: every output must be low
    repeat (3) @(negedge clk);
    check_output("reset_servo", servo, 0);
    check_output("reset_pump", pump, 0);
    check_output("reset_frame_st", frame_st, 0);
    check_output("reset_busy", busy, 0);
    rst = 1'b0;

    // Frame 0 after reset: widths are 850 and all pumps are on
    apply_stimulus(3'b000, 500, -1, 0);
    // Ramp ch0 down. The change at cnt 100 must not alter the current pulse. Glitch ch1 for 3 cycles
    apply_stimulus(3'b001, 100, 1, 30);
    apply_stimulus(3'b001, 500, -1, 0);
    apply_stimulus(3'b001, 500, -1, 0);
    // Reverse while pw0 is 550
    apply_stimulus(3'b000, 200, -1, 0);
    // sel[2] rises at cnt 100
    apply_stimulus(3'b100, 100, -1, 0);
    // Ramp ch0 and ch2 down until both clamp at POS_A
    repeat (6) apply_stimulus(3'b101, 300, -1, 0);

    // Randomized frames
    repeat (12) begin
      rnd_sel = NCH'($urandom);
      g = int'($urandom_range(0, NCH));
      if (g < NCH && rnd_sel[g] != sel_m[g]) g = -1;
      if (g == NCH) g = -1;
      apply_stimulus(rnd_sel, 100 + int'($urandom_range(0, 800)), g,
                     20 + int'($urandom_range(0, 40)));
    end

`ifdef RAIN_LOCK_EN
    // Rain locks every pump but leaves the servos alone
    repeat (10) @(negedge clk);
    rain = 1'b1;
    repeat (7) @(negedge clk);
    check_output("rain_pump_off", pump, 0);
    exp_vec = '1;
    check_output("rain_servo_kept", servo, exp_vec);
    repeat (13) @(negedge clk);
    rain = 1'b0;
    repeat (7) @(negedge clk);
    exp_vec = ~sel_m;
    check_output("rain_pump_restored", pump, exp_vec);
`endif

    // Asynchronous reset in the middle of a pulse: outputs must drop with no clock edge
    repeat (40) @(negedge clk);
    exp_vec = '1;
    check_output("pre_async_servo_high", servo, exp_vec);
    #2 rst = 1'b1;
    #1;
    check_output("async_reset_servo", servo, 0);
    check_output("async_reset_pump", pump, 0);
    check_output("async_reset_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
